// File: rtl/usb_tx_packet_streamer_if.sv
// Bundles the buffer-read, encoder byte handshake and control/status lines
// of the USB TX packet streamer.
// master: the streamer itself. slave: controller, data buffer and encoder side.
interface usb_tx_packet_streamer_if;
  logic       start;
  logic       abort;
  logic [6:0] byte_count;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_packet_data;
  logic       get_tx_packet_data;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;
  logic       busy;
  logic       underrun;
  logic       done;

  modport master (
    input  start, abort, byte_count, buffer_occupancy, tx_packet_data, tx_ready,
    output get_tx_packet_data, tx_byte, tx_valid, tx_last, busy, underrun, done
  );

  modport slave (
    output start, abort, byte_count, buffer_occupancy, tx_packet_data, tx_ready,
    input  get_tx_packet_data, tx_byte, tx_valid, tx_last, busy, underrun, done
  );
endinterface

// File: rtl/usb_tx_packet_streamer.sv
// USB TX packet streamer: pops payload bytes from the data buffer and hands
// them to the TX encoder over a valid/ready byte handshake.
// Build option USB_TX_CRC16_EN: when defined, the USB CRC16 is appended,
// low byte first, and tx_last marks the CRC high byte. When undefined the
// encoder owns the CRC and tx_last marks the final payload byte.
module usb_tx_packet_streamer #(
  parameter int          MAX_BYTES = 64,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
  input logic clk,
  input logic rst,
  usb_tx_packet_streamer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
`ifdef USB_TX_CRC16_EN
    S_CRC_LO,
    S_CRC_HI,
`endif
    S_DONE
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [6:0] r_rem;
  logic [7:0] r_tx_byte;
  logic [6:0] w_clamp;
  logic       w_pop, w_hs, w_start;
  logic [7:0] w_tx_byte;
  logic       w_tx_valid, w_tx_last;

`ifdef USB_TX_CRC16_EN
  logic [15:0] r_crc;

  // One byte of reflected CRC16 (poly 0xA001), LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] t;
    t = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++)
      t = t[0] ? ((t >> 1) ^ 16'hA001) : (t >> 1);
    return t;
  endfunction
`else
  // Seed only matters when the CRC is generated here.
  logic w_unused_crc_init;
  assign w_unused_crc_init = ^CRC_INIT;
`endif

  assign w_clamp = (bus.byte_count > 7'(MAX_BYTES)) ? 7'(MAX_BYTES) : bus.byte_count;
  assign w_start = (r_state == S_IDLE) && bus.start && !bus.abort;
  assign w_hs    = w_tx_valid && bus.tx_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, pop strobe and encoder-side outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx_byte   = r_tx_byte;
    w_tx_valid  = 1'b0;
    w_tx_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
`ifdef USB_TX_CRC16_EN
          w_state_nxt = (w_clamp != 7'd0) ? S_LOAD : S_CRC_LO;
`else
          w_state_nxt = (w_clamp != 7'd0) ? S_LOAD : S_DONE;
`endif
        end
      end
      S_LOAD: begin
        if (bus.buffer_occupancy != 7'd0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        w_tx_valid = 1'b1;
`ifdef USB_TX_CRC16_EN
        if (bus.tx_ready) w_state_nxt = (r_rem > 7'd1) ? S_LOAD : S_CRC_LO;
`else
        w_tx_last = (r_rem == 7'd1);
        if (bus.tx_ready) w_state_nxt = (r_rem > 7'd1) ? S_LOAD : S_DONE;
`endif
      end
`ifdef USB_TX_CRC16_EN
      S_CRC_LO: begin
        w_tx_valid = 1'b1;
        w_tx_byte  = ~r_crc[7:0];
        if (bus.tx_ready) w_state_nxt = S_CRC_HI;
      end
      S_CRC_HI: begin
        w_tx_valid = 1'b1;
        w_tx_last  = 1'b1;
        w_tx_byte  = ~r_crc[15:8];
        if (bus.tx_ready) w_state_nxt = S_DONE;
      end
`endif
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort beats everything, including a pending pop.
    if (bus.abort) begin
      w_state_nxt = S_IDLE;
      w_pop       = 1'b0;
    end
  end

  // Byte counter, output byte register and running CRC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem     <= 7'd0;
      r_tx_byte <= 8'h00;
`ifdef USB_TX_CRC16_EN
      r_crc     <= CRC_INIT;
`endif
    end else if (bus.abort) begin
      r_rem <= 7'd0;
`ifdef USB_TX_CRC16_EN
      r_crc <= CRC_INIT;
`endif
    end else begin
      if (w_start) begin
        r_rem <= w_clamp;
`ifdef USB_TX_CRC16_EN
        r_crc <= CRC_INIT;
`endif
      end
      if (w_pop) r_tx_byte <= bus.tx_packet_data;
      if ((r_state == S_SEND) && w_hs) begin
        r_rem <= r_rem - 7'd1;
`ifdef USB_TX_CRC16_EN
        r_crc <= crc16_byte(r_crc, r_tx_byte);
`endif
      end
    end
  end

  assign bus.get_tx_packet_data = w_pop;
  assign bus.tx_byte            = w_tx_byte;
  assign bus.tx_valid           = w_tx_valid;
  assign bus.tx_last            = w_tx_last;
  assign bus.busy               = (r_state != S_IDLE);
  assign bus.underrun           = (r_state == S_LOAD) && (bus.buffer_occupancy == 7'd0);
  assign bus.done               = (r_state == S_DONE) && !bus.abort;

endmodule

// File: tb/tb_usb_tx_packet_streamer.sv
// Directed bench for usb_tx_packet_streamer: a byte-buffer model feeds the
// streamer, a sink records accepted bytes; expectations follow the build
// option USB_TX_CRC16_EN.
module tb_usb_tx_packet_streamer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  usb_tx_packet_streamer_if bus();
  usb_tx_packet_streamer dut (.clk(clk), .rst(rst), .bus(bus));

  // Data buffer model: wr advanced by stimulus, rd by the pop strobe.
  logic [7:0] mem [0:127];
  int wr = 0;
  int rd = 0;
  always @(posedge clk) if (bus.get_tx_packet_data) rd <= rd + 1;
  assign bus.buffer_occupancy = 7'(wr - rd);
  assign bus.tx_packet_data   = mem[rd[6:0]];

  // Sink / event monitor, sampled mid-cycle.
  logic [7:0] cap_b [$];
  logic       cap_l [$];
  int done_cnt = 0;
  int pop_cnt  = 0;
  always @(negedge clk) if (!rst) begin
    if (bus.tx_valid && bus.tx_ready) begin
      cap_b.push_back(bus.tx_byte);
      cap_l.push_back(bus.tx_last);
    end
    if (bus.done) done_cnt++;
    if (bus.get_tx_packet_data) pop_cnt++;
  end

  int n_cmp = 0;
  int n_err = 0;
  int cap_base, pop_base, done_base;
  logic [7:0] pay [$];
  logic [7:0] exp_b [$];

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

`ifdef USB_TX_CRC16_EN
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    c = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction
`endif

  task cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task clr();
    cap_base  = cap_b.size();
    pop_base  = pop_cnt;
    done_base = done_cnt;
    pay.delete();
    exp_b.delete();
  endtask

  task push(input logic [7:0] b);
    mem[wr[6:0]] = b;
    wr = wr + 1;
    pay.push_back(b);
  endtask

  task build_exp(input int n);
`ifdef USB_TX_CRC16_EN
    logic [15:0] c;
    c = 16'hFFFF;
`endif
    for (int i = 0; i < n; i++) begin
      exp_b.push_back(pay[i]);
`ifdef USB_TX_CRC16_EN
      c = crc_byte(c, pay[i]);
`endif
    end
`ifdef USB_TX_CRC16_EN
    exp_b.push_back(~c[7:0]);
    exp_b.push_back(~c[15:8]);
`endif
  endtask

  task start_pkt(input logic [6:0] n);
    bus.start = 1'b1; bus.byte_count = n;
    cyc(1);
    bus.start = 1'b0;
  endtask

  task wait_done(input string tag, input int max);
    int c;
    c = 0;
    while (done_cnt == done_base && c < max) begin cyc(1); c++; end
    chk({tag, " done_seen"}, 32'(done_cnt != done_base), 1);
    cyc(2);
  endtask

  task wait_valid(input string tag);
    int c;
    c = 0;
    while (!bus.tx_valid && c < 20) begin cyc(1); c++; end
    chk({tag, " valid_seen"}, 32'(bus.tx_valid), 1);
  endtask

  task check_pkt(input string tag, input int pops);
    chk({tag, " len"}, 32'(cap_b.size() - cap_base), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && cap_base + i < cap_b.size(); i++) begin
      chk($sformatf("%s byte%0d", tag, i), 32'(cap_b[cap_base + i]), 32'(exp_b[i]));
      chk($sformatf("%s last%0d", tag, i), 32'(cap_l[cap_base + i]), 32'(i == exp_b.size() - 1));
    end
    chk({tag, " pops"}, 32'(pop_cnt - pop_base), 32'(pops));
    chk({tag, " done_cnt"}, 32'(done_cnt - done_base), 1);
  endtask

  initial begin
    logic [7:0] b0;
    int stab_err;
    bus.start = 0; bus.abort = 0; bus.byte_count = 0; bus.tx_ready = 0;

    // Reset state
    cyc(3);
    chk("rst tx_byte", 32'(bus.tx_byte), 0);
    chk("rst tx_valid", 32'(bus.tx_valid), 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst get", 32'(bus.get_tx_packet_data), 0);
    rst = 1'b0;
    cyc(1);
    chk("idle done", 32'(bus.done), 0);
    chk("idle last", 32'(bus.tx_last), 0);
    chk("idle underrun", 32'(bus.underrun), 0);

    // T1: '1'..'9', streaming
    clr();
    for (int i = 0; i < 9; i++) push(8'h31 + 8'(i));
    build_exp(9);
    bus.tx_ready = 1;
    start_pkt(7'd9);
    chk("t1 busy", 32'(bus.busy), 1);
    wait_done("t1", 60);
    check_pkt("t1", 9);
`ifdef USB_TX_CRC16_EN
    chk("t1 crc_lo", 32'(cap_b[cap_base + 9]), 32'h0C8);
    chk("t1 crc_hi", 32'(cap_b[cap_base + 10]), 32'h0B4);
`endif

    // T2: zero-length packet
    clr();
    build_exp(0);
    start_pkt(7'd0);
    wait_done("t2", 20);
    check_pkt("t2", 0);

    // T3: AA BB CC with 5-cycle stalls on every byte
    clr();
    push(8'hAA); push(8'hBB); push(8'hCC);
    build_exp(3);
    bus.tx_ready = 0;
    stab_err = 0;
    start_pkt(7'd3);
    for (int j = 0; j < exp_b.size(); j++) begin
      wait_valid("t3");
      b0 = bus.tx_byte;
      for (int s = 0; s < 5; s++) begin
        cyc(1);
        if (!bus.tx_valid || bus.tx_byte !== b0) stab_err++;
      end
      bus.tx_ready = 1;
      cyc(1);
      bus.tx_ready = 0;
    end
    chk("t3 stable", 32'(stab_err), 0);
    bus.tx_ready = 1;
    wait_done("t3", 20);
    check_pkt("t3", 3);

    // T4: underrun, count 4 with only 2 bytes buffered
    clr();
    push(8'h01); push(8'h02);
    start_pkt(7'd4);
    cyc(12);
    chk("t4 underrun", 32'(bus.underrun), 1);
    chk("t4 no_pop", 32'(bus.get_tx_packet_data), 0);
    chk("t4 pops_so_far", 32'(pop_cnt - pop_base), 2);
    push(8'h03); push(8'h04);
    build_exp(4);
    #0;
    chk("t4 underrun_clear", 32'(bus.underrun), 0);
    wait_done("t4", 40);
    check_pkt("t4", 4);

    // T5: abort while presenting byte 2 of 8
    clr();
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    bus.tx_ready = 0;
    start_pkt(7'd8);
    wait_valid("t5a");
    bus.tx_ready = 1; cyc(1); bus.tx_ready = 0;
    wait_valid("t5b");
    bus.abort = 1;
    cyc(1);
    bus.abort = 0;
    chk("t5 busy", 32'(bus.busy), 0);
    chk("t5 valid", 32'(bus.tx_valid), 0);
    cyc(4);
    chk("t5 no_done", 32'(done_cnt - done_base), 0);
    chk("t5 pops", 32'(pop_cnt - pop_base), 2);
    chk("t5 sent", 32'(cap_b.size() - cap_base), 1);
    wr = rd;                        // controller clears the buffer
    clr();
    push(8'h5A);
    build_exp(1);
    bus.tx_ready = 1;
    start_pkt(7'd1);
    wait_done("t5r", 20);
    check_pkt("t5r", 1);

    // T6: count 100 clamps to 64, start while busy ignored
    clr();
    for (int i = 0; i < 64; i++) push(8'(i * 3 + 7));
    build_exp(64);
    start_pkt(7'd100);
    cyc(5);
    start_pkt(7'd3);
    wait_done("t6", 300);
    check_pkt("t6", 64);
    cyc(4);
    chk("t6 idle_after", 32'(bus.busy), 0);

    // T7: two-byte packet
    clr();
    push(8'hE1); push(8'h7E);
    build_exp(2);
    start_pkt(7'd2);
    wait_done("t7", 20);
    check_pkt("t7", 2);

    // T8: reset in the middle of a packet
    clr();
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    bus.tx_ready = 0;
    start_pkt(7'd4);
    wait_valid("t8");
    rst = 1'b1;
    #1;
    chk("t8 busy", 32'(bus.busy), 0);
    chk("t8 valid", 32'(bus.tx_valid), 0);
    chk("t8 tx_byte", 32'(bus.tx_byte), 0);
    cyc(2);
    rst = 1'b0;
    wr = rd;
    cyc(2);
    chk("t8 idle", 32'(bus.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
